// File: rtl/operand_fetch.sv
// Operand fetch stage: drives register-file reads, merges EX/MEM/WB forwards,
// stalls on load hazards and registers operands for EX. Optional OPFETCH_STATS_EN adds counters.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_use1,
  input  logic            id_use2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_we,
  input  logic            id_is_load,
  output logic            rf_re1,
  output logic            rf_re2,
  output logic [AW-1:0]   rf_raddr1,
  output logic [AW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            ex_fwd_we,
  input  logic            ex_fwd_is_load,
  input  logic [AW-1:0]   ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            mem_fwd_we,
  input  logic            mem_fwd_pending,
  input  logic [AW-1:0]   mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_rd_we,
  output logic            ex_is_load,
  output logic            stall
`ifdef OPFETCH_STATS_EN
  ,
  output logic [31:0]     stat_stall_cycles,
  output logic [31:0]     stat_fwd_count
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  state_t state_q, state_d;

  logic [1:0]      src_use;
  logic [AW-1:0]   src_rs    [2];
  logic [XLEN-1:0] src_rdata [2];
  logic [XLEN-1:0] src_op    [2];
  logic [1:0]      src_live;
  logic [1:0]      ex_hit;
  logic [1:0]      mem_hit;
  logic [1:0]      wb_hit;
  logic [1:0]      src_haz;
  logic            hazard;
  logic            accept;

  assign src_use      = {id_use2, id_use1};
  assign src_rs[0]    = id_rs1;
  assign src_rs[1]    = id_rs2;
  assign src_rdata[0] = rf_rdata1;
  assign src_rdata[1] = rf_rdata2;

  assign rf_raddr1 = id_rs1;
  assign rf_raddr2 = id_rs2;
  assign rf_re1    = id_valid && src_live[0];
  assign rf_re2    = id_valid && src_live[1];

  // The youngest matching stage wins; a pending MEM load only blocks when EX does not shadow it.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_live[i] = src_use[i] && (src_rs[i] != '0);
      ex_hit[i]   = ex_fwd_we && (ex_fwd_rd == src_rs[i]);
      mem_hit[i]  = mem_fwd_we && (mem_fwd_rd == src_rs[i]);
      wb_hit[i]   = wb_we && (wb_addr == src_rs[i]);
      src_haz[i]  = src_live[i] &&
                    ((ex_hit[i] && ex_fwd_is_load) ||
                     (!ex_hit[i] && mem_hit[i] && mem_fwd_pending));
      if (!src_live[i])
        src_op[i] = '0;
      else if (ex_hit[i] && !ex_fwd_is_load)
        src_op[i] = ex_fwd_data;
      else if (mem_hit[i] && !mem_fwd_pending)
        src_op[i] = mem_fwd_data;
      else if (wb_hit[i])
        src_op[i] = wb_data;
      else
        src_op[i] = src_rdata[i];
    end
  end

  assign hazard   = |src_haz;
  assign id_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_rd      <= '0;
      ex_rd_we   <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_op1     <= src_op[0];
      ex_op2     <= src_op[1];
      ex_rd      <= id_rd;
      ex_rd_we   <= id_rd_we;
      ex_is_load <= id_is_load;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // Back-pressure alone never enters STALL; only a load hazard on a live instruction does.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (id_valid && hazard && !flush) state_d = STALL;
      STALL:   if (!hazard || !id_valid || flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign stall = (state_q == STALL);

`ifdef OPFETCH_STATS_EN
  logic [1:0] src_fwd;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_fwd[i] = src_live[i] &&
                   ((ex_hit[i] && !ex_fwd_is_load) ||
                    (mem_hit[i] && !mem_fwd_pending) ||
                    wb_hit[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_fwd_count    <= '0;
    end else begin
      if (state_q == STALL)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (accept)
        stat_fwd_count <= stat_fwd_count + 32'(src_fwd[0]) + 32'(src_fwd[1]);
    end
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: RF path, forward priority,
// load hazards, x0/unused sources, back-pressure, flush and reset.
module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_use1, id_use2, id_rd_we, id_is_load;
  logic            rf_re1, rf_re2;
  logic [AW-1:0]   rf_raddr1, rf_raddr2;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic            ex_fwd_we, ex_fwd_is_load;
  logic [AW-1:0]   ex_fwd_rd;
  logic [XLEN-1:0] ex_fwd_data;
  logic            mem_fwd_we, mem_fwd_pending;
  logic [AW-1:0]   mem_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid, ex_ready;
  logic [XLEN-1:0] ex_op1, ex_op2;
  logic [AW-1:0]   ex_rd;
  logic            ex_rd_we, ex_is_load;
  logic            stall;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_is_load(ex_fwd_is_load),
    .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_pending(mem_fwd_pending),
    .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .stall(stall)
  );

  // Register-file model: x5=0x11, x6=0x22, any other register reads 0x100+index.
  function automatic logic [XLEN-1:0] rfValue(input logic [AW-1:0] addr);
    if (addr == 5'd5)      return 32'h11;
    else if (addr == 5'd6) return 32'h22;
    else                   return 32'h100 + 32'(addr);
  endfunction

  assign rf_rdata1 = rfValue(rf_raddr1);
  assign rf_rdata2 = rfValue(rf_raddr2);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [AW-1:0] rs1, input logic use1,
                               input logic [AW-1:0] rs2, input logic use2,
                               input logic [AW-1:0] rd, input logic rdWe);
    id_valid   = valid;
    id_rs1     = rs1;
    id_use1    = use1;
    id_rs2     = rs2;
    id_use2    = use2;
    id_rd      = rd;
    id_rd_we   = rdWe;
    id_is_load = 1'b0;
    #1;
  endtask

  task automatic clearForwards();
    ex_fwd_we = 0; ex_fwd_is_load = 0; ex_fwd_rd = '0; ex_fwd_data = '0;
    mem_fwd_we = 0; mem_fwd_pending = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; ex_ready = 1;
    clearForwards();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_ex_valid", 32'(ex_valid), 0);
    checkOutput("rst_ex_op1", ex_op1, 0);
    checkOutput("rst_stall", 32'(stall), 0);
    rst = 0;

    // add x7, x5, x6 straight from the register file
    applyStimulus(1, 5, 1, 6, 1, 7, 1);
    checkOutput("rf_re1", 32'(rf_re1), 1);
    checkOutput("rf_re2", 32'(rf_re2), 1);
    checkOutput("rf_id_ready", 32'(id_ready), 1);
    tick();
    checkOutput("rf_ex_valid", 32'(ex_valid), 1);
    checkOutput("rf_op1", ex_op1, 32'h11);
    checkOutput("rf_op2", ex_op2, 32'h22);
    checkOutput("rf_rd", 32'(ex_rd), 7);
    checkOutput("rf_rd_we", 32'(ex_rd_we), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("drain_ex_valid", 32'(ex_valid), 0);

    // forward priority EX > MEM > WB
    ex_fwd_we = 1; ex_fwd_rd = 5; ex_fwd_data = 32'hAA;
    mem_fwd_we = 1; mem_fwd_rd = 5; mem_fwd_data = 32'hBB;
    wb_we = 1; wb_addr = 5; wb_data = 32'hCC;
    applyStimulus(1, 5, 1, 6, 1, 7, 1);
    tick();
    checkOutput("fwd_ex", ex_op1, 32'hAA);
    checkOutput("fwd_ex_op2_rf", ex_op2, 32'h22);
    ex_fwd_we = 0;
    tick();
    checkOutput("fwd_mem", ex_op1, 32'hBB);
    mem_fwd_we = 0;
    tick();
    checkOutput("fwd_wb", ex_op1, 32'hCC);
    clearForwards();

    // pending MEM load blocks, unless a younger EX result shadows it
    mem_fwd_we = 1; mem_fwd_rd = 5; mem_fwd_pending = 1;
    applyStimulus(1, 5, 1, 6, 1, 7, 1);
    checkOutput("pend_id_ready", 32'(id_ready), 0);
    ex_fwd_we = 1; ex_fwd_rd = 5; ex_fwd_data = 32'h55;
    #1;
    checkOutput("shadow_id_ready", 32'(id_ready), 1);
    tick();
    checkOutput("shadow_op1", ex_op1, 32'h55);
    clearForwards();

    // load-use then resolution from MEM
    ex_fwd_we = 1; ex_fwd_is_load = 1; ex_fwd_rd = 5;
    #1;
    checkOutput("lu_id_ready", 32'(id_ready), 0);
    tick();
    checkOutput("lu_stall", 32'(stall), 1);
    checkOutput("lu_ex_valid", 32'(ex_valid), 0);
    clearForwards();
    mem_fwd_we = 1; mem_fwd_rd = 5; mem_fwd_data = 32'h1234;
    #1;
    checkOutput("lu_release_ready", 32'(id_ready), 1);
    tick();
    checkOutput("lu_op1", ex_op1, 32'h1234);
    checkOutput("lu_ex_valid2", 32'(ex_valid), 1);
    checkOutput("lu_stall_clear", 32'(stall), 0);
    clearForwards();

    // x0 source ignores forwarding; unused source reads zero; rd=x0 passes through
    ex_fwd_we = 1; ex_fwd_rd = 0; ex_fwd_data = 32'hFF;
    applyStimulus(1, 0, 1, 6, 0, 0, 1);
    checkOutput("x0_re1", 32'(rf_re1), 0);
    checkOutput("x0_re2", 32'(rf_re2), 0);
    checkOutput("x0_id_ready", 32'(id_ready), 1);
    tick();
    checkOutput("x0_op1", ex_op1, 0);
    checkOutput("x0_op2", ex_op2, 0);
    checkOutput("x0_rd_we", 32'(ex_rd_we), 1);
    checkOutput("x0_stall", 32'(stall), 0);
    clearForwards();

    // back-pressure holds the bundle and does not stall
    ex_ready = 0;
    applyStimulus(1, 5, 1, 6, 1, 9, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_id_ready", 32'(id_ready), 0);
      tick();
      checkOutput("bp_ex_valid", 32'(ex_valid), 1);
      checkOutput("bp_op1", ex_op1, 0);
      checkOutput("bp_rd_we", 32'(ex_rd_we), 1);
      checkOutput("bp_stall", 32'(stall), 0);
    end
    ex_ready = 1;
    #1;
    checkOutput("bp_release_ready", 32'(id_ready), 1);
    tick();
    checkOutput("bp_new_op1", ex_op1, 32'h11);
    checkOutput("bp_new_rd", 32'(ex_rd), 9);

    // flush with a live bundle and a waiting instruction
    flush = 1;
    #1;
    checkOutput("flush_id_ready", 32'(id_ready), 0);
    tick();
    checkOutput("flush_ex_valid", 32'(ex_valid), 0);
    flush = 0;

    // reset in the middle of a stall
    ex_ready = 0;
    applyStimulus(1, 6, 1, 0, 0, 3, 1);
    tick();
    checkOutput("pre_rst_valid", 32'(ex_valid), 1);
    ex_fwd_we = 1; ex_fwd_is_load = 1; ex_fwd_rd = 5;
    applyStimulus(1, 5, 1, 0, 0, 4, 1);
    tick();
    checkOutput("pre_rst_stall", 32'(stall), 1);
    rst = 1;
    tick();
    checkOutput("mid_rst_valid", 32'(ex_valid), 0);
    checkOutput("mid_rst_op1", ex_op1, 0);
    checkOutput("mid_rst_rd", 32'(ex_rd), 0);
    checkOutput("mid_rst_stall", 32'(stall), 0);
    clearForwards();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    tick();
    checkOutput("post_rst_stall", 32'(stall), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-stage initiator for the register-file read ports.
- Accepts decoded instructions, drives register-file read enables and addresses, and merges read data with forwarded results from EX, MEM and WB.
- Detects load-use and pending-load hazards and stalls the upstream.
- Presents registered operands to EX over a valid/ready handshake.

Parameters:
XLEN, 32, operand/data width
AW, 5, register address width (32 architectural registers, x0 hardwired zero)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush (branch/jump redirect)
id_valid  in  1  decoded instruction valid
id_ready  out  1  instruction accepted this cycle when id_valid && id_ready
id_rs1, id_rs2  in  AW  source register addresses
id_use1, id_use2  in  1  instruction reads rs1 / rs2
id_rd  in  AW  destination register
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
rf_re1, rf_re2  out  1  register-file read enables (combinational)
rf_raddr1, rf_raddr2  out  AW  register-file read addresses (combinational)
rf_rdata1, rf_rdata2  in  XLEN  register-file read data, same-cycle combinational return
ex_fwd_we, ex_fwd_is_load  in  1  EX-stage instruction writes rd / is a load
ex_fwd_rd  in  AW  EX-stage destination
ex_fwd_data  in  XLEN  EX-stage ALU result
mem_fwd_we, mem_fwd_pending  in  1  MEM-stage writes rd / load data not yet returned
mem_fwd_rd  in  AW  MEM-stage destination
mem_fwd_data  in  XLEN  MEM-stage result
wb_we  in  1  writeback enable
wb_addr  in  AW  writeback address
wb_data  in  XLEN  writeback data
ex_valid  out  1  operand bundle valid
ex_ready  in  1  EX accepts bundle
ex_op1, ex_op2  out  XLEN  resolved operands
ex_rd  out  AW  destination passed through
ex_rd_we, ex_is_load  out  1  passed through
stall  out  1  registered; high while in STALL state

Behaviour:
- Reset: ex_valid=0, ex_op1=ex_op2=0, ex_rd=0, ex_rd_we=0, ex_is_load=0, stall=0, FSM=RUN. Reset has priority over flush and handshakes; an in-flight bundle is dropped.
- Read port drive (combinational):
  - rf_raddrN = id_rsN.
  - rf_reN = id_valid && id_useN && id_rsN!=0.
- Operand resolution per source N (combinational, applied at acceptance), first match wins:
  1. !id_useN or id_rsN==0 -> 0.
  2. ex_fwd_we && ex_fwd_rd==id_rsN && !ex_fwd_is_load -> ex_fwd_data.
  3. mem_fwd_we && mem_fwd_rd==id_rsN && !mem_fwd_pending -> mem_fwd_data.
  4. wb_we && wb_addr==id_rsN -> wb_data.
  5. otherwise rf_rdataN.
- Forwarding only ever consults the youngest matching stage. An older stage never bypasses a younger matching one.
- Hazard (combinational), per used nonzero source:
  - (ex_fwd_we && ex_fwd_rd==rs && ex_fwd_is_load) -> load-use, or
  - (mem_fwd_we && mem_fwd_rd==rs && mem_fwd_pending) with no EX match -> pending load.
- id_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- Output register, one-cycle latency:
  - On accept, load operands and passthrough fields; ex_valid=1 next cycle.
  - If ex_valid && ex_ready and no accept -> ex_valid=0.
  - A held bundle (ex_valid && !ex_ready) keeps all fields stable.
- Flush: ex_valid=0 next cycle, no accept in the flush cycle; other fields may hold stale values.
- FSM:
  - RUN -> STALL when id_valid && hazard && !flush.
  - STALL -> RUN when !hazard, or !id_valid, or flush.
  - stall is the registered state.
  - Back-pressure from ex_ready alone does not enter STALL.
- id_rd_we with id_rd==0: passed through unchanged (EX/WB ignore x0 writes).

Optional Feature:
- Macro OPFETCH_STATS_EN.
- Defined:
  - Adds outputs stat_stall_cycles[31:0], incremented each cycle in STALL, and stat_fwd_count[31:0], incremented per accepted operand resolved by rules 2-4. Each accept adds 0, 1 or 2.
  - Both are cleared by rst and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Register-file path: rf holds x5=0x11, x6=0x22; accept add x7,x5,x6 with no forwards -> rf_re1=rf_re2=1, next cycle ex_valid=1, ex_op1=0x11, ex_op2=0x22.
- Forward priority: x5 matched by EX (0xAA), MEM (0xBB) and WB (0xCC) -> ex_op1=0xAA. Drop EX match -> 0xBB. Drop MEM match -> 0xCC.
- Load-use: ex_fwd_is_load, ex_fwd_rd=5, instruction reads x5 -> id_ready=0, stall=1 next cycle. Next cycle MEM rd=5, pending=0, data=0x1234 -> accept, ex_op1=0x1234, stall returns 0.
- x0 and unused source: rs1=0 with EX forwarding rd=0 data 0xFF, and id_use2=0 -> ex_op1=0, ex_op2=0, rf_re1=rf_re2=0, no stall.
- Back-pressure: ex_ready=0 for 3 cycles with a new id_valid -> id_ready=0, output fields stable, stall=0. On ex_ready=1 the new instruction is accepted.
- Flush and reset: flush while ex_valid=1 and id_valid=1 -> id_ready=0, ex_valid=0 next cycle. rst mid-STALL -> all outputs zero, FSM=RUN next cycle.
